// File: rtl/tdm_demux.sv
// Two-slot TDM demultiplexer: locks onto sync-marked frames and presents both channel words together.
// Optional sticky framing-error flag is built when TDM_DEMUX_ERR_EN is defined.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             q_valid,
  output logic             slot,
  output logic             in_frame,
  output logic [7:0]       frame_cnt,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic             q_valid_q, q_valid_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             frame_err;

  // Only accepted words move the FSM; q_valid is the one output that drops back on idle cycles.
  always_comb begin
    state_d     = state_q;
    hold0_d     = hold0_q;
    q0_d        = q0_q;
    q1_d        = q1_q;
    q_valid_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    frame_err   = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            hold0_d = din;
            state_d = S1;
          end
        end
        S0: begin
          if (sync) begin
            hold0_d = din;
            state_d = S1;
          end else begin
            frame_err = 1'b1;
            state_d   = HUNT;
          end
        end
        S1: begin
          if (sync) begin
            // A fresh slot-0 word restarts the frame rather than dropping lock.
            frame_err = 1'b1;
            hold0_d   = din;
          end else begin
            q0_d        = hold0_q;
            q1_d        = din;
            q_valid_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = S0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      hold0_q     <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      q_valid_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold0_q     <= hold0_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      q_valid_q   <= q_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef TDM_DEMUX_ERR_EN
  logic err_q, err_d;

  // A new error wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (frame_err)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  logic [1:0] unused_err_sigs;
  assign unused_err_sigs = {err_clr, frame_err};
  assign err = 1'b0;
`endif

  assign q0        = q0_q;
  assign q1        = q1_q;
  assign q_valid   = q_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign slot      = (state_q == S1);
  assign in_frame  = (state_q != HUNT);
  assign state_dbg = state_q;

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  one clock; reset asynchronous, active-low.
REQ-004 din  input  WIDTH  time-multiplexed word stream from a 2-slot mux source.
REQ-005 din_valid  input  1  din qualifier; word accepted on rising clk when high.
REQ-006 sync  input  1  marks an accepted word as slot 0 (frame start); sampled only with din_valid.
REQ-007 err_clr  input  1  clears sticky err (used only when TDM_DEMUX_ERR_EN is defined).
REQ-008 q0  output  WIDTH  registered channel-0 word of last complete frame.
REQ-009 q1  output  WIDTH  registered channel-1 word of last complete frame.
REQ-010 q_valid  output  1  one-cycle pulse: q0/q1 updated with a new frame.
REQ-011 slot  output  1  slot expected for next accepted word (0 or 1).
REQ-012 in_frame  output  1  high when frame-locked (state not HUNT).
REQ-013 frame_cnt  output  8  count of completed frames.
REQ-014 err  output  1  sticky framing-error flag.

Function
REQ-015 FSM states: HUNT, S0 (expect slot 0), S1 (expect slot 1); all transitions on accepted words only; din_valid low holds all state and outputs except q_valid.
REQ-016 HUNT: accepted word with sync=1 -> hold0<=din, go S1; sync=0 -> word discarded, stay HUNT.
REQ-017 S1: accepted word with sync=0 -> q0<=hold0, q1<=din, q_valid=1 next cycle, frame_cnt+1, go S0.
REQ-018 S1: accepted word with sync=1 -> framing error; hold0<=din, stay S1 (new frame restarts); q0/q1 unchanged.
REQ-019 S0: accepted word with sync=1 -> hold0<=din, go S1.
REQ-020 S0: accepted word with sync=0 -> framing error; word discarded, go HUNT.
REQ-021 Latency: q0/q1/q_valid update on the clk edge that accepts the slot-1 word (visible the following cycle); q_valid high exactly one cycle per frame.
REQ-022 q0/q1 hold previous frame values until next completed frame; never partially updated.
REQ-023 frame_cnt wraps 255 -> 0 without flag.
REQ-024 slot = 1 in S1, 0 in HUNT and S0; in_frame = 0 in HUNT only.

Reset
REQ-025 reset_n low asynchronously forces: state HUNT, hold0=0, q0=0, q1=0, q_valid=0, frame_cnt=0, err=0; slot=0, in_frame=0.
REQ-026 Reset asserted mid-frame discards hold0; first frame after release requires a sync word.
REQ-027 Release is synchronous to clk; first word accepted on first rising edge with reset_n high.

Configuration
REQ-028 Macro TDM_DEMUX_ERR_EN defined: err set on any framing error (REQ-018, REQ-020), cleared by err_clr; error and err_clr in same cycle -> err=1.
REQ-029 TDM_DEMUX_ERR_EN undefined: err tied 0, err_clr ignored; FSM recovery behaviour identical.

Verification
REQ-030 Reset, then words (0xA1,sync=1),(0xB2,sync=0) -> q0=0xA1, q1=0xB2, q_valid one pulse, frame_cnt=1, err=0.
REQ-031 From HUNT, (0x11,sync=0),(0x22,sync=1),(0x33,sync=0) -> 0x11 dropped; q0=0x22, q1=0x33, frame_cnt=1.
REQ-032 Locked; (0x44,sync=1),(0x55,sync=1),(0x66,sync=0) -> q0=0x55, q1=0x66; err=1 with macro, 0 without.
REQ-033 Locked in S0; (0x77,sync=0) -> in_frame=0, q0/q1 unchanged; err=1 (macro); err_clr pulse -> err=0.
REQ-034 Send 256 valid frames with din_valid gaps between words -> frame_cnt=0 after wrap, 256 q_valid pulses, outputs stable during gaps.
REQ-035 Assert reset_n low after slot-0 word 0x99 -> all outputs 0 immediately; after release, (0xAB,sync=0) discarded, state HUNT.
